// File: rtl/regfile_2w2r.sv
// Two-write, two-read general-purpose register file for the 16-bit RISC datapath.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_2w2r #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [DATA_W-1:0] WD1,
    input  logic              WE2,
    input  logic [ADDR_W-1:0] WA2,
    input  logic [DATA_W-1:0] WD2,
    output logic              WCOLL
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr1_ok;
    logic              wr2_ok;
    logic              coll;

    // A write to the hardwired zero register is dropped before it can collide.
    always_comb begin
        wr1_ok = WE1 && !((ZERO_REG != 0) && (WA1 == '0));
        wr2_ok = WE2 && !((ZERO_REG != 0) && (WA2 == '0));
        coll   = wr1_ok && wr2_ok && (WA1 == WA2);
    end

    // NOTE: the array is plain flops, not a RAM macro, so it can and must be
    // cleared by the asynchronous reset along with the collision flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            WCOLL <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; port 2 is written last so it wins
            // a same-address collision.
            if (wr1_ok) begin
                regs[WA1] <= WD1;
            end
            if (wr2_ok) begin
                regs[WA2] <= WD2;
            end
            WCOLL <= coll;
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        RD1 = regs[RA1];
`ifdef REGFILE_BYPASS_EN
        if (wr1_ok && (WA1 == RA1)) begin
            RD1 = WD1;
        end
        if (wr2_ok && (WA2 == RA1)) begin
            RD1 = WD2;
        end
`endif
        if ((ZERO_REG != 0) && (RA1 == '0)) begin
            RD1 = '0;
        end
    end

    always_comb begin
        RD2 = regs[RA2];
`ifdef REGFILE_BYPASS_EN
        if (wr1_ok && (WA1 == RA2)) begin
            RD2 = WD1;
        end
        if (wr2_ok && (WA2 == RA2)) begin
            RD2 = WD2;
        end
`endif
        if ((ZERO_REG != 0) && (RA2 == '0)) begin
            RD2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed self-checking bench for regfile_2w2r: default 16x16 build with zero
// register, plus a 32x32 instance with ZERO_REG=0 for the full-array sweep.
module tb_regfile_2w2r;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  ra1, ra2, wa1, wa2;
    logic [15:0] rd1, rd2, wd1, wd2;
    logic        we1, we2, wcoll;

    logic [4:0]  s_ra1, s_ra2, s_wa1, s_wa2;
    logic [31:0] s_rd1, s_rd2, s_wd1, s_wd2;
    logic        s_we1, s_we2, s_wcoll;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_2w2r u_dut (
        .CLK(clk), .RST_N(rst_n),
        .RA1(ra1), .RA2(ra2), .RD1(rd1), .RD2(rd2),
        .WE1(we1), .WA1(wa1), .WD1(wd1),
        .WE2(we2), .WA2(wa2), .WD2(wd2),
        .WCOLL(wcoll)
    );

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut32 (
        .CLK(clk), .RST_N(rst_n),
        .RA1(s_ra1), .RA2(s_ra2), .RD1(s_rd1), .RD2(s_rd2),
        .WE1(s_we1), .WA1(s_wa1), .WD1(s_wd1),
        .WE2(s_we2), .WA2(s_wa2), .WD2(s_wd2),
        .WCOLL(s_wcoll)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int a);
        return 32'hC35A_0000 | (a << 8) | (31 - a);
    endfunction

    initial begin
        rst_n = 1'b0;
        {we1, we2} = '0;
        {ra1, ra2, wa1, wa2} = '0;
        {wd1, wd2} = '0;
        {s_we1, s_we2} = '0;
        {s_ra1, s_ra2, s_wa1, s_wa2} = '0;
        {s_wd1, s_wd2} = '0;

        #2;
        check("reset_rd1", 32'(rd1), 32'h0);
        check("reset_wcoll", 32'(wcoll), 32'h0);
        // This write spans the edge at t=5 while reset is held and must be lost.
        we1 = 1'b1; wa1 = 4'd6; wd1 = 16'h7777;
        #5;
        we1 = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();

        // Preload R5 through a collision so WCOLL is high when reset hits.
        we1 = 1'b1; wa1 = 4'd5; wd1 = 16'h9999;
        we2 = 1'b1; wa2 = 4'd5; wd2 = 16'h1234;
        tick();
        we1 = 1'b0; we2 = 1'b0;
        ra1 = 4'd5; ra2 = 4'd6;
        #1;
        check("preload_r5", 32'(rd1), 32'h1234);
        check("preload_wcoll", 32'(wcoll), 32'h1);
        check("write_in_reset_lost", 32'(rd2), 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_rd1", 32'(rd1), 32'h0);
        check("async_reset_wcoll", 32'(wcoll), 32'h0);
        rst_n = 1'b1;
        tick();

        // Dual write to distinct registers.
        we1 = 1'b1; wa1 = 4'd3; wd1 = 16'hAAAA;
        we2 = 1'b1; wa2 = 4'd7; wd2 = 16'h5555;
        tick();
        we1 = 1'b0; we2 = 1'b0;
        ra1 = 4'd3; ra2 = 4'd7;
        #1;
        check("dual_rd1", 32'(rd1), 32'hAAAA);
        check("dual_rd2", 32'(rd2), 32'h5555);
        check("dual_wcoll", 32'(wcoll), 32'h0);

        // Single collision: port 2 wins, WCOLL for one cycle.
        we1 = 1'b1; wa1 = 4'd9; wd1 = 16'h1111;
        we2 = 1'b1; wa2 = 4'd9; wd2 = 16'h2222;
        tick();
        we1 = 1'b0; we2 = 1'b0;
        ra1 = 4'd9;
        #1;
        check("coll_r9", 32'(rd1), 32'h2222);
        check("coll_wcoll_hi", 32'(wcoll), 32'h1);
        tick();
        check("coll_wcoll_lo", 32'(wcoll), 32'h0);

        // Back-to-back collisions hold WCOLL high.
        we1 = 1'b1; wa1 = 4'd10; wd1 = 16'h0101;
        we2 = 1'b1; wa2 = 4'd10; wd2 = 16'h0202;
        tick();
        check("b2b_wcoll_1", 32'(wcoll), 32'h1);
        wd1 = 16'h0303; wd2 = 16'h0404;
        tick();
        check("b2b_wcoll_2", 32'(wcoll), 32'h1);
        we1 = 1'b0; we2 = 1'b0;
        ra1 = 4'd10;
        #1;
        check("b2b_r10", 32'(rd1), 32'h0404);
        tick();
        check("b2b_wcoll_lo", 32'(wcoll), 32'h0);

        // Zero register ignores writes on both ports and never collides.
        we1 = 1'b1; wa1 = 4'd0; wd1 = 16'hFFFF;
        we2 = 1'b1; wa2 = 4'd0; wd2 = 16'hFFFF;
        ra1 = 4'd0; ra2 = 4'd0;
        #1;
        check("zero_bypass_rd1", 32'(rd1), 32'h0);
        tick();
        we1 = 1'b0; we2 = 1'b0;
        #1;
        check("zero_rd1", 32'(rd1), 32'h0);
        check("zero_rd2", 32'(rd2), 32'h0);
        check("zero_wcoll", 32'(wcoll), 32'h0);

        // Read-during-write of R4, with and without forwarding.
        we2 = 1'b1; wa2 = 4'd4; wd2 = 16'h0001;
        tick();
        we2 = 1'b0;
        we1 = 1'b1; wa1 = 4'd4; wd1 = 16'hBEEF;
        ra1 = 4'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_before_edge", 32'(rd1), 32'hBEEF);
`else
        check("nobypass_before_edge", 32'(rd1), 32'h0001);
`endif
        tick();
        we1 = 1'b0;
        #1;
        check("after_edge_r4", 32'(rd1), 32'hBEEF);

        // Forwarding priority when both ports write the read address.
        we1 = 1'b1; wa1 = 4'd11; wd1 = 16'h1357;
        we2 = 1'b1; wa2 = 4'd11; wd2 = 16'h2468;
        ra2 = 4'd11;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_prio_rd2", 32'(rd2), 32'h2468);
`else
        check("nobypass_old_rd2", 32'(rd2), 32'h0000);
`endif
        tick();
        we1 = 1'b0; we2 = 1'b0;
        #1;
        check("prio_r11", 32'(rd2), 32'h2468);
        check("prio_wcoll", 32'(wcoll), 32'h1);

        // Full-array sweep on the 32x32 instance, two registers per edge.
        for (int a = 0; a < 32; a += 2) begin
            s_we1 = 1'b1; s_wa1 = 5'(a);     s_wd1 = pat(a);
            s_we2 = 1'b1; s_wa2 = 5'(a + 1); s_wd2 = pat(a + 1);
            tick();
        end
        s_we1 = 1'b0; s_we2 = 1'b0;
        #1;
        check("sweep_wcoll", 32'(s_wcoll), 32'h0);
        for (int a = 0; a < 32; a++) begin
            s_ra1 = 5'(a);
            s_ra2 = 5'(31 - a);
            #1;
            check($sformatf("sweep_rd1_%0d", a), s_rd1, pat(a));
            check($sformatf("sweep_rd2_%0d", 31 - a), s_rd2, pat(31 - a));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
